// File: rtl/disp_chan_sched_if.sv
// CPU write handshake bundle for the display channel scheduler.
// The CPU side drives the request; the scheduler returns ack and busy.
interface disp_chan_sched_if;
  logic cpu_wr_req;
  logic cpu_wr_ack;
  logic busy;

  modport master (
    output cpu_wr_req,
    input  cpu_wr_ack,
    input  busy
  );

  modport slave (
    input  cpu_wr_req,
    output cpu_wr_ack,
    output busy
  );
endinterface

// File: rtl/disp_chan_sched.sv
// Channel scheduler for the 8-channel 32-bit display multiplexer.
// Rotates the channel select over an enable mask (auto mode) or advances it on
// a synchronised step button, and sequences CPU writes into channel 0 with a
// 4-phase req/ack handshake that produces a single-cycle latch strobe EN.
module disp_chan_sched #(
  parameter int DWELL_CYCLES = 50_000_000,
  parameter int CNT_W        = 26
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                auto_mode,
  input  logic [7:0]          chan_mask,
  input  logic                step_btn,
  input  logic                cpu_focus,
  disp_chan_sched_if.slave    cpu,
  output logic [2:0]          Test,
  output logic                EN
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO   = '0;
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_ACK   = 2'd2
  } wr_state_e;

  wr_state_e        state_r;
  wr_state_e        state_nxt_s;
  logic             en_r;
  logic             ack_r;
  logic             busy_r;

  logic [2:0]       test_r;
  logic [2:0]       test_nxt_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_nxt_s;

  logic             step_s1_r;
  logic             step_s2_r;
  logic             step_s3_r;
  logic             auto_r;

  logic             step_pulse_s;
  logic             strobe_s;
  logic             mode_chg_s;

  // First enabled channel after c, searching upward and wrapping 7 -> 0.
  // Falls back to c itself when no other channel is enabled.
  function automatic logic [2:0] nxt_chan(input logic [2:0] c, input logic [7:0] m);
    logic [2:0] res;
    logic [2:0] idx;
    res = c;
    // Walk offsets from farthest to nearest so the nearest enabled one wins.
    for (int k = 32'sd7; k >= 32'sd1; k--) begin
      idx = c + k[2:0];
      if (m[idx]) begin
        res = idx;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

  assign step_pulse_s = step_s2_r & ~step_s3_r;
  assign mode_chg_s   = auto_mode ^ auto_r;
  assign strobe_s     = (state_nxt_s == ST_LATCH);

  // Write handshake next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cpu.cpu_wr_req) begin
          state_nxt_s = ST_LATCH;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_LATCH: begin
        // The strobe always completes, even if req has already dropped.
        state_nxt_s = ST_ACK;
      end
      ST_ACK: begin
        if (!cpu.cpu_wr_req) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_ACK;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Handshake state and Moore outputs registered from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= ST_IDLE;
      en_r    <= 1'b0;
      ack_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      en_r    <= (state_nxt_s == ST_LATCH);
      ack_r   <= (state_nxt_s == ST_ACK);
      busy_r  <= (state_nxt_s != ST_IDLE);
    end
  end

  // Channel select priority: empty mask, focused write, disabled current
  // channel, step button, dwell expiry, then dwell counting.
  always_comb begin
    test_nxt_s = test_r;
    cnt_nxt_s  = cnt_r;
    if (chan_mask == 8'h00) begin
      test_nxt_s = 3'd0;
      cnt_nxt_s  = CNT_ZERO;
    end else if (strobe_s && cpu_focus) begin
      test_nxt_s = 3'd0;
      cnt_nxt_s  = CNT_ZERO;
    end else if (!chan_mask[test_r]) begin
      test_nxt_s = nxt_chan(test_r, chan_mask);
      cnt_nxt_s  = CNT_ZERO;
    end else if (step_pulse_s) begin
      test_nxt_s = nxt_chan(test_r, chan_mask);
      cnt_nxt_s  = CNT_ZERO;
    end else if (auto_mode && (cnt_r == DWELL_LAST)) begin
      test_nxt_s = nxt_chan(test_r, chan_mask);
      cnt_nxt_s  = CNT_ZERO;
    end else if (auto_mode) begin
      test_nxt_s = test_r;
      if (mode_chg_s) begin
        cnt_nxt_s = CNT_ZERO;
      end else begin
        cnt_nxt_s = cnt_r + CNT_ONE;
      end
    end else begin
      // Manual mode keeps the dwell counter parked at zero.
      test_nxt_s = test_r;
      cnt_nxt_s  = CNT_ZERO;
    end
  end

  // Channel select and dwell counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      test_r <= 3'd0;
      cnt_r  <= CNT_ZERO;
    end else begin
      test_r <= test_nxt_s;
      cnt_r  <= cnt_nxt_s;
    end
  end

  // Step button synchroniser, edge-history flop and registered mode copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_s1_r <= 1'b0;
      step_s2_r <= 1'b0;
      step_s3_r <= 1'b0;
      auto_r    <= 1'b0;
    end else begin
      step_s1_r <= step_btn;
      step_s2_r <= step_s1_r;
      step_s3_r <= step_s2_r;
      auto_r    <= auto_mode;
    end
  end

  assign Test           = test_r;
  assign EN             = en_r;
  assign cpu.cpu_wr_ack = ack_r;
  assign cpu.busy       = busy_r;

endmodule
